// File: rtl/ecc_core.sv
// ecc_core: 256-bit modular add/sub/square/multiply unit with start/done handshake.
// Multiplication is interleaved MSB-first shift-add, one multiplier bit per cycle,
// keeping the partial result below p after every iteration.
module ecc_core (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         start,
    input  logic [255:0] a,
    input  logic [255:0] b,
    input  logic [255:0] prime,
    input  logic [2:0]   alu_sel,
    output logic [255:0] alu_result,
    output logic         done
);

    // StWrite is the single result-write step shared by every operation, so that
    // done and alu_result always rise together one edge after the final compute step.
    typedef enum logic [2:0] {
        StIdle,
        StAddSub,
        StMult,
        StWrite,
        StDone
    } state_t;

    state_t       state_q;
    logic [255:0] a_q;
    logic [255:0] b_q;
    logic [255:0] p_q;
    logic         op_q;      // add/sub: 1 = sub; mult: 1 = multiply by b, 0 = square
    logic [255:0] r_q;       // working result, always < p
    logic [7:0]   cnt_q;     // multiplier bit index, 255 down to 0

    logic [256:0] sum;
    logic [256:0] diff;
    logic [255:0] addsub_res;
    logic         mult_bit;
    logic [257:0] dbl;
    logic [255:0] dbl_red;
    logic [257:0] acc;
    logic [255:0] mult_next;

    // Single-cycle modular add/sub on the captured operands.
    always_comb begin
        sum  = {1'b0, a_q} + {1'b0, b_q};
        diff = {1'b0, a_q} - {1'b0, b_q};
        addsub_res = '0;
        if (!op_q) begin
            // sum < 2p, so one conditional subtraction lands in [0, p)
            addsub_res = (sum >= {1'b0, p_q}) ? (sum[255:0] - p_q) : sum[255:0];
        end else begin
            // diff[256] is the borrow, i.e. a < b; wrap back into range by adding p
            addsub_res = diff[256] ? (diff[255:0] + p_q) : diff[255:0];
        end
    end

    // One shift-add iteration: r = 2r mod p, then r = (r + bit*a) mod p.
    always_comb begin
        mult_bit  = op_q ? b_q[cnt_q] : a_q[cnt_q];
        dbl       = {1'b0, r_q, 1'b0};
        dbl_red   = (dbl >= {2'b00, p_q}) ? (dbl[255:0] - p_q) : dbl[255:0];
        acc       = mult_bit ? ({2'b00, dbl_red} + {2'b00, a_q}) : {2'b00, dbl_red};
        mult_next = (acc >= {2'b00, p_q}) ? (acc[255:0] - p_q) : acc[255:0];
    end

    // Control FSM with registered result and done.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= StIdle;
            a_q        <= '0;
            b_q        <= '0;
            p_q        <= '0;
            op_q       <= 1'b0;
            r_q        <= '0;
            cnt_q      <= '0;
            alu_result <= '0;
            done       <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b;
                        p_q   <= prime;
                        op_q  <= alu_sel[0];
                        r_q   <= '0;
                        cnt_q <= 8'd255;
                        unique case (alu_sel)
                            3'b000, 3'b001: state_q <= StAddSub;
                            3'b010, 3'b011: state_q <= StMult;
                            default:        state_q <= StWrite;  // reserved: writes r = 0
                        endcase
                    end
                end
                StAddSub: begin
                    r_q     <= addsub_res;
                    state_q <= StWrite;
                end
                StMult: begin
                    r_q <= mult_next;
                    if (cnt_q == 8'd0) begin
                        state_q <= StWrite;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                StWrite: begin
                    alu_result <= r_q;
                    done       <= 1'b1;
                    state_q    <= StDone;
                end
                StDone: begin
                    // A held start never re-triggers; it must drop first.
                    if (!start) begin
                        done    <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ecc_core.sv
// tb_ecc_core: directed tests for ecc_core against a big-integer reference model.
module tb_ecc_core;

    localparam logic [255:0] P = (256'd1 << 255) - 256'd19;

    logic         i_clk;
    logic         i_rst_n;
    logic         start;
    logic [255:0] a;
    logic [255:0] b;
    logic [255:0] prime;
    logic [2:0]   alu_sel;
    logic [255:0] alu_result;
    logic         done;

    int total = 0;
    int bad   = 0;

    ecc_core dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .prime      (prime),
        .alu_sel    (alu_sel),
        .alu_result (alu_result),
        .done       (done)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string nm, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, got, exp);
        end
    endtask

    // Reference arithmetic using plain wide integer operators.
    function automatic logic [255:0] ref_op(input logic [255:0] x, input logic [255:0] y,
                                            input logic [255:0] p, input logic [2:0] s);
        logic [511:0] w;
        case (s)
            3'd0:    w = ({256'd0, x} + {256'd0, y}) % {256'd0, p};
            3'd1:    w = ({256'd0, x} + {256'd0, p} - {256'd0, y}) % {256'd0, p};
            3'd2:    w = ({256'd0, x} * {256'd0, x}) % {256'd0, p};
            3'd3:    w = ({256'd0, x} * {256'd0, y}) % {256'd0, p};
            default: w = '0;
        endcase
        return w[255:0];
    endfunction

    function automatic int ref_lat(input logic [2:0] s);
        if (s <= 3'd1) return 2;
        if (s <= 3'd3) return 257;
        return 1;
    endfunction

    // Behavioural model: a capture starts a countdown of the op's latency; result and
    // done appear together when it expires; done clears once start is seen low.
    logic         m_busy;
    logic         m_done;
    int           m_cnt;
    logic [255:0] m_res;
    logic [255:0] m_pend;

    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_cnt  = 0;
            m_res  = '0;
            m_pend = '0;
        end else if (m_busy) begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) begin
                m_busy = 1'b0;
                m_done = 1'b1;
                m_res  = m_pend;
            end
        end else if (m_done) begin
            if (!start) m_done = 1'b0;
        end else if (start) begin
            m_pend = ref_op(a, b, prime, alu_sel);
            m_cnt  = ref_lat(alu_sel);
            m_busy = 1'b1;
        end
    end

    // Every-cycle comparison against the model; inputs only move at negedge+1.
    always @(negedge i_clk) begin
        if (i_rst_n) begin
            check("model_done", {255'd0, done}, {255'd0, m_done});
            check("model_result", alu_result, m_res);
        end
    end

    function automatic logic [255:0] rnd256();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic drive_gap();
        @(negedge i_clk);
        #1;
    endtask

    // Full handshake: request, scramble inputs after capture, wait for done, release.
    task automatic run_op(input string nm, input logic [255:0] xa, input logic [255:0] xb,
                          input logic [255:0] xp, input logic [2:0] s,
                          input logic [255:0] exp, input int lat);
        int n;
        drive_gap();
        a = xa; b = xb; prime = xp; alu_sel = s; start = 1'b1;
        @(posedge i_clk);
        #1;
        a = rnd256(); b = rnd256(); prime = rnd256(); alu_sel = 3'($urandom);
        n = 1;
        while (!done && n <= 400) begin
            @(posedge i_clk);
            #1;
            if (!done) n++;
        end
        check({nm, "_latency"}, 256'(n), 256'(lat));
        check({nm, "_result"}, alu_result, exp);
        drive_gap();
        start = 1'b0;
        @(posedge i_clk);
        #1;
        check({nm, "_done_fall"}, {255'd0, done}, 256'd0);
    endtask

    initial begin
        int n;
        i_rst_n = 1'b0; start = 1'b0; a = '0; b = '0; prime = P; alu_sel = '0;
        repeat (3) @(posedge i_clk);
        drive_gap();
        i_rst_n = 1'b1;
        #1;
        check("reset_done", {255'd0, done}, 256'd0);
        check("reset_result", alu_result, 256'd0);

        // Literal expectations also pin the reference model.
        check("ref_mul_literal", ref_op(P - 256'h4F2, P - 256'h852, P, 3'd3), 256'h292584);
        check("ref_sub_literal", ref_op(256'd3, 256'd5, 256'd7, 3'd1), 256'd5);

        run_op("add", P - 256'h4F2, P - 256'h852, P, 3'd0, P - 256'hD44, 2);
        run_op("sub", P - 256'h4F2, P - 256'h852, P, 3'd1, 256'h360, 2);
        run_op("sub_small", 256'd3, 256'd5, 256'd7, 3'd1, 256'd5, 2);
        run_op("mul", P - 256'h4F2, P - 256'h852, P, 3'd3, 256'h292584, 257);
        run_op("mul_by_p", P - 256'h1F88, P, P, 3'd3, 256'd0, 257);
        run_op("square3", 256'd3, 256'd0, P, 3'd2, 256'd9, 257);
        run_op("reserved", 256'd77, 256'd88, P, 3'b111, 256'd0, 1);
        run_op("after_reserved", 256'd10, 256'd20, P, 3'd0, 256'd30, 2);
        run_op("sub_wrap", 256'd1, P - 256'd1, P, 3'd1, 256'd2, 2);

        // Back-to-back: start held through done must not retrigger.
        drive_gap();
        a = 256'd100; b = 256'd23; prime = P; alu_sel = 3'd1; start = 1'b1;
        @(posedge i_clk);
        #1;
        a = 256'd5; b = 256'd6;
        n = 0;
        while (!done && n < 10) begin
            @(posedge i_clk);
            #1;
            n++;
        end
        check("b2b_first_result", alu_result, 256'd77);
        repeat (5) @(posedge i_clk);
        #1;
        check("b2b_hold_done", {255'd0, done}, 256'd1);
        check("b2b_hold_result", alu_result, 256'd77);
        drive_gap();
        start = 1'b0;
        @(posedge i_clk);
        #1;
        check("b2b_done_fall", {255'd0, done}, 256'd0);
        repeat (8) @(posedge i_clk);
        #1;
        check("b2b_idle_result", alu_result, 256'd77);
        run_op("b2b_second", P - 256'd2, 256'd7, P, 3'd3, P - 256'd14, 257);

        // Reset mid-multiply aborts with immediate clear.
        drive_gap();
        a = P - 256'd5; b = P - 256'd9; prime = P; alu_sel = 3'd3; start = 1'b1;
        repeat (100) @(posedge i_clk);
        drive_gap();
        i_rst_n = 1'b0;
        start = 1'b0;
        #1;
        check("midreset_done", {255'd0, done}, 256'd0);
        check("midreset_result", alu_result, 256'd0);
        repeat (3) @(posedge i_clk);
        drive_gap();
        i_rst_n = 1'b1;
        repeat (300) @(posedge i_clk);
        #1;
        check("post_reset_idle_done", {255'd0, done}, 256'd0);
        check("post_reset_idle_result", alu_result, 256'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ecc_core.md
# ecc_core

256-bit modular arithmetic unit for the elliptic-curve datapath. It computes (a op b) mod prime for addition, subtraction, multiplication and squaring. Operation is selected by `alu_sel`, with a start/done handshake. Point-arithmetic controllers above it sequence field operations through this block one at a time.

## Interface
- No parameters; all operand widths are fixed at 256 bits.
- `i_clk`  in  1  sole clock; all state updates on the rising edge.
- `i_rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  level request; sampled in IDLE.
- `a`  in  256  operand A.
- `b`  in  256  operand B.
- `prime`  in  256  modulus p.
- `alu_sel`  in  3  operation select: 000 add, 001 sub, 010 square (a·a), 011 multiply, others reserved.
- `alu_result`  out  256  result register.
- `done`  out  1  result valid.

## Operation
- Modulus constraints: p is odd, 3 ≤ p < 2^255 (target p = 2^255−19).
- Operand constraints: a < p; b < p for add/sub; b may be any 256-bit value for multiply (b = p gives 0).
- States: IDLE, ADDSUB, MULT, DONE.
- IDLE → capture step: when start=1, register a, b, prime and alu_sel.
  - Go to ADDSUB for 000/001.
  - Go to MULT for 010/011.
  - For reserved codes, load result 0 and go to DONE.
- ADDSUB (one cycle), using a 257-bit intermediate:
  - Add: s = a+b; if s ≥ p, subtract p.
  - Sub: d = a−b; if a < b, add p.
  - Result to `alu_result`, then go to DONE.
- MULT: interleaved MSB-first shift-add over 256 iterations, one bit per cycle, 258-bit intermediate.
  - Initial r = 0.
  - Per bit i from 255 down to 0: r = 2r; if r ≥ p, r −= p; if b[i], r += a; if r ≥ p, r −= p.
  - The invariant r < p holds after every iteration.
  - Square uses a as the multiplier in place of b.
  - After bit 0, load r into `alu_result` and go to DONE.
- DONE: `done`=1 and `alu_result` held stable. Stay while start=1; go to IDLE when start=0.
- `alu_result` changes only when a new result is written. It keeps its value through IDLE until the next operation completes.
- Inputs a, b, prime and alu_sel may change freely after the capture cycle without affecting the running operation.

## Timing
- Reset (asynchronous, immediate): `alu_result`=0, `done`=0, state IDLE, iteration counter 0. Reset mid-operation aborts it; no result is written.
- Capture edge = first rising edge with start=1 in IDLE (edge k).
- Latency:
  - Add/sub: `done` rises after edge k+2.
  - Mult/square: `done` rises after edge k+257 (256 iteration cycles, plus capture, plus write).
  - Reserved codes: `done` rises after edge k+1.
- `done` is a registered level. It falls on the first edge after start is sampled low in DONE.
- If start is held high continuously, no new operation begins. start must be seen low (DONE→IDLE) before the next capture.
- `done` is guaranteed low in the cycle following any new capture, so a requester waiting on `done` never sees a stale result.
- start going low while busy is ignored; the operation completes and `done` is asserted in DONE.
- `done` and the new `alu_result` become visible on the same edge.

## Test plan
- Reset: assert i_rst_n=0 mid-multiply → `done`=0 and `alu_result`=0 immediately; release with start=0 → block stays idle.
- Multiply, p=2^255−19, a=p−0x4F2, b=p−0x852 → `alu_result`=0x292584; `done` rises exactly 257 cycles after capture.
- Multiply, a=p−0x1F88, b=p → `alu_result`=0. Then square with a=3 → 9.
- Add: a=p−0x4F2, b=p−0x852 → p−0xD44. Sub: same operands → 0x360. Sub: a=3, b=5, p=7 → 5. Each with `done` 2 cycles after capture.
- Back-to-back handshake: hold start high through `done`, drop start for 10 cycles, change operands, raise start.
  - `done` falls one cycle after start drops and stays low until the new result.
  - The result matches the new operands.
  - Operand changes after capture do not affect the result.
- Reserved alu_sel=3'b111 → `alu_result`=0, `done` after 1 cycle. Next valid operation completes normally.
